seg_p2s_ctrl: RTL and testbench

Sequencer for the board's serial seven-segment display chain (64-bit frame: 8 digits × 8 segment bits).
- Accepts a parallel 64-bit segment frame from the display encoders on a start request.
- Shifts the frame out MSB first on SEGDT/SEGCLK at a programmable bit rate.
- Reports busy/done.
- Issues display clear pulses on request.
- Replaces free-running shift-register chains gated by an all-ones finish detect.

---
 rtl/seg_p2s_ctrl_if.sv | 27 ++
 rtl/seg_p2s_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_p2s_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_p2s_ctrl_if.sv
// Parallel-side handshake for the seven-segment frame serialiser: frame request/clear in,
// busy/done status out.
interface seg_p2s_ctrl_if #(
  parameter int unsigned FRAME_W = 64
);
  logic               start;
  logic               clr;
  logic [FRAME_W-1:0] data;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output clr,
    output data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  clr,
    input  data,
    output busy,
    output done
  );
endinterface

// File: rtl/seg_p2s_ctrl.sv
// Serialises a parallel segment frame MSB first onto the display's SEGDT/SEGCLK chain and
// issues timed clear pulses. Every output comes straight from a flop.
module seg_p2s_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned FRAME_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  seg_p2s_ctrl_if.slave bus,
  output logic          SEGCLK,
  output logic          SEGDT,
  output logic          SEGCLR,
  output logic          SEGEN
);

  localparam int unsigned BitW = $clog2(FRAME_W);
  localparam logic [7:0]      PhaseLast = 8'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FRAME_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShiftLo,
    StShiftHi,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [7:0]         phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               segclk_q, segclk_d;
  logic               segdt_q, segdt_d;
  logic               segclr_q, segclr_d;
  logic               segen_q, segen_d;
  logic               phase_end;

  assign phase_end = (phase_q == PhaseLast);

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    phase_d  = phase_q + 8'd1;
    busy_d   = busy_q;
    done_d   = 1'b0;
    segclk_d = segclk_q;
    segdt_d  = segdt_q;
    segclr_d = segclr_q;
    segen_d  = 1'b1;

    case (state_q)
      StIdle: begin
        phase_d = '0;
        // Clear wins; a start arriving alongside it is simply dropped.
        if (bus.clr) begin
          state_d  = StClear;
          segclr_d = 1'b0;
          busy_d   = 1'b1;
        end else if (bus.start) begin
          state_d  = StShiftLo;
          sr_d     = bus.data;
          bit_d    = '0;
          busy_d   = 1'b1;
          segclk_d = 1'b0;
          segdt_d  = bus.data[FRAME_W-1];
        end
      end
      StClear: begin
        if (phase_end) begin
          state_d  = StIdle;
          phase_d  = '0;
          segclr_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      StShiftLo: begin
        if (phase_end) begin
          state_d  = StShiftHi;
          phase_d  = '0;
          segclk_d = 1'b1;
        end
      end
      StShiftHi: begin
        if (phase_end) begin
          phase_d = '0;
          if (bit_q == BitLast) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            segdt_d = 1'b1;
          end else begin
            // Data only moves while the chain clock is low again.
            state_d  = StShiftLo;
            sr_d     = {sr_q[FRAME_W-2:0], 1'b0};
            segdt_d  = sr_q[FRAME_W-2];
            segclk_d = 1'b0;
            bit_d    = bit_q + BitW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        phase_d = '0;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      segclk_q <= 1'b1;
      segdt_q  <= 1'b1;
      segclr_q <= 1'b1;
      segen_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      segclk_q <= segclk_d;
      segdt_q  <= segdt_d;
      segclr_q <= segclr_d;
      segen_q  <= segen_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign SEGCLK   = segclk_q;
  assign SEGDT    = segdt_q;
  assign SEGCLR   = segclr_q;
  assign SEGEN    = segen_q;

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// Directed bench for seg_p2s_ctrl with CLK_DIV = 4, 2 and 1 instances.
module tb_seg_p2s_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic segclk4, segdt4, segclr4, segen4;
  logic segclk2, segdt2, segclr2, segen2;
  logic segclk1, segdt1, segclr1, segen1;

  seg_p2s_ctrl_if #(.FRAME_W(64)) bus4 ();
  seg_p2s_ctrl_if #(.FRAME_W(64)) bus2 ();
  seg_p2s_ctrl_if #(.FRAME_W(64)) bus1 ();

  seg_p2s_ctrl #(.CLK_DIV(4), .FRAME_W(64)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .SEGCLK(segclk4), .SEGDT(segdt4), .SEGCLR(segclr4), .SEGEN(segen4)
  );
  seg_p2s_ctrl #(.CLK_DIV(2), .FRAME_W(64)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .SEGCLK(segclk2), .SEGDT(segdt2), .SEGCLR(segclr2), .SEGEN(segen2)
  );
  seg_p2s_ctrl #(.CLK_DIV(1), .FRAME_W(64)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .SEGCLK(segclk1), .SEGDT(segdt1), .SEGCLR(segclr1), .SEGEN(segen1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one frame on the CLK_DIV=2 instance and records the serial side for 300 cycles.
  task automatic capture2(input logic [63:0] d, input int change_at, output logic [63:0] rx,
                          output int rises, output int done_at, output int done_cycles,
                          output int busy_cnt, output int wave_err);
    logic prev;
    logic exp_clk;
    rx = '0; rises = 0; done_at = -1; done_cycles = 0; busy_cnt = 0; wave_err = 0;
    bus2.data  = d;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    prev = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c == change_at) bus2.data = '0;
      if (segclk2 && !prev) begin
        rises++;
        rx = {rx[62:0], segdt2};
      end
      prev = segclk2;
      if (bus2.busy) busy_cnt++;
      if (bus2.done) begin
        done_cycles++;
        if (done_at < 0) done_at = c;
      end
      if (c < 256) begin
        exp_clk = ((c / 2) % 2) == 1;
        if (segclk2 !== exp_clk || segdt2 !== d[63 - c / 4]) wave_err++;
      end else if (segclk2 !== 1'b1 || segdt2 !== 1'b1) begin
        wave_err++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({segclk4, segdt4, segclr4, bus4.busy, bus4.done, segen4} !== 6'b111000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 111000",
               {segclk4, segdt4, segclr4, bus4.busy, bus4.done, segen4});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (segen4 !== 1'b0) begin
      n_fail++;
      $display("FAIL segen_before_edge: got %b want 0", segen4);
    end
    tick();
    n_checks++;
    if (segen4 !== 1'b1) begin
      n_fail++;
      $display("FAIL segen_after_edge: got %b want 1", segen4);
    end
  endtask

  task automatic test_frame();
    logic [63:0] rx;
    int rises, done_at, done_cycles, busy_cnt, wave_err;
    capture2(64'h8000_0000_0000_0001, -1, rx, rises, done_at, done_cycles, busy_cnt, wave_err);
    n_checks++;
    if (wave_err !== 0) begin
      n_fail++;
      $display("FAIL frame_waveform: got %0d bad cycles want 0", wave_err);
    end
    n_checks++;
    if (rises !== 64) begin
      n_fail++;
      $display("FAIL frame_rises: got %0d want 64", rises);
    end
    n_checks++;
    if (rx !== 64'h8000_0000_0000_0001) begin
      n_fail++;
      $display("FAIL frame_data: got %h want 8000000000000001", rx);
    end
    n_checks++;
    if (done_at !== 256 || done_cycles !== 1) begin
      n_fail++;
      $display("FAIL frame_done: got at %0d x%0d want at 256 x1", done_at, done_cycles);
    end
    n_checks++;
    if (busy_cnt !== 256) begin
      n_fail++;
      $display("FAIL frame_busy: got %0d want 256", busy_cnt);
    end
  endtask

  task automatic test_data_change();
    logic [63:0] rx;
    int rises, done_at, done_cycles, busy_cnt, wave_err;
    capture2(64'hA5A5_5A5A_0F0F_F0F0, 5, rx, rises, done_at, done_cycles, busy_cnt, wave_err);
    n_checks++;
    if (rx !== 64'hA5A5_5A5A_0F0F_F0F0) begin
      n_fail++;
      $display("FAIL data_change_stream: got %h want a5a55a5a0f0ff0f0", rx);
    end
    n_checks++;
    if (wave_err !== 0) begin
      n_fail++;
      $display("FAIL data_change_waveform: got %0d bad cycles want 0", wave_err);
    end
  endtask

  task automatic test_clear();
    int clr_err, busy_cnt, clk_err, done_cnt;
    logic exp_clr;
    clr_err = 0; busy_cnt = 0; clk_err = 0; done_cnt = 0;
    bus4.data  = 64'hFFFF_0000_FFFF_0000;
    bus4.clr   = 1'b1;
    bus4.start = 1'b1;
    tick();
    bus4.clr   = 1'b0;
    bus4.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      exp_clr = (c >= 4);
      if (segclr4 !== exp_clr) clr_err++;
      if (bus4.busy) busy_cnt++;
      if (segclk4 !== 1'b1) clk_err++;
      if (bus4.done) done_cnt++;
      tick();
    end
    n_checks++;
    if (clr_err !== 0) begin
      n_fail++;
      $display("FAIL clear_pulse: got %0d bad cycles want 0", clr_err);
    end
    n_checks++;
    if (busy_cnt !== 4) begin
      n_fail++;
      $display("FAIL clear_busy: got %0d want 4", busy_cnt);
    end
    n_checks++;
    if (clk_err !== 0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL clear_no_shift: got clk_err %0d done %0d want 0 0", clk_err, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d_at [3];
    int n_done;
    n_done = 0;
    bus1.data  = 64'h0123_4567_89AB_CDEF;
    bus1.start = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      if (bus1.done) begin
        if (n_done < 3) d_at[n_done] = c;
        n_done++;
        if (n_done == 3) bus1.start = 1'b0;
      end
      tick();
    end
    bus1.start = 1'b0;
    n_checks++;
    if (n_done !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 3", n_done);
    end
    if (n_done >= 3) begin
      n_checks++;
      if (d_at[0] !== 128 || d_at[1] - d_at[0] !== 130 || d_at[2] - d_at[1] !== 130) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d %0d %0d want 128 258 388",
                 d_at[0], d_at[1], d_at[2]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rx;
    int rises, done_at, done_cycles, busy_cnt, wave_err, done_cnt;
    done_cnt = 0;
    bus2.data  = 64'hDEAD_BEEF_0123_4567;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    repeat (122) tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({segclk2, segdt2, segclr2, bus2.busy, bus2.done, segen2} !== 6'b111000) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b want 111000",
               {segclk2, segdt2, segclr2, bus2.busy, bus2.done, segen2});
    end
    for (int c = 0; c < 10; c++) begin
      if (bus2.done) done_cnt++;
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus2.done || bus2.busy) done_cnt++;
      tick();
    end
    n_checks++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d want 0", done_cnt);
    end
    capture2(64'h1357_9BDF_2468_ACE0, -1, rx, rises, done_at, done_cycles, busy_cnt, wave_err);
    n_checks++;
    if (rx !== 64'h1357_9BDF_2468_ACE0 || rises !== 64) begin
      n_fail++;
      $display("FAIL abort_next_frame: got %h/%0d want 13579bdf2468ace0/64", rx, rises);
    end
    n_checks++;
    if (done_at !== 256) begin
      n_fail++;
      $display("FAIL abort_next_done: got %0d want 256", done_at);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus4.start = 1'b0; bus4.clr = 1'b0; bus4.data = '0;
    bus2.start = 1'b0; bus2.clr = 1'b0; bus2.data = '0;
    bus1.start = 1'b0; bus1.clr = 1'b0; bus1.data = '0;
    test_reset();
    test_frame();
    test_data_change();
    test_clear();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
